// File: rtl/otg_hpi_bus_master.sv
// Avalon-MM slave that runs one timed HPI bus cycle toward the CY7C67200
// EZ-OTG for each CPU access. Write accesses drive the data pins.
// Read accesses sample the device data pins into readdata.
module otg_hpi_bus_master #(
  parameter int SETUP_CYCLES    = 2,
  parameter int STROBE_CYCLES   = 4,
  parameter int HOLD_CYCLES     = 2,
  parameter int RECOVERY_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        waitrequest,
  output logic [1:0]  hpi_addr,
  output logic        hpi_cs_n,
  output logic        hpi_rd_n,
  output logic        hpi_wr_n,
  output logic [15:0] hpi_data_out,
  output logic        hpi_data_oe,
  input  logic [15:0] hpi_data_in
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    HOLD    = 3'd3,
    RECOVER = 3'd4
  } state_t;

  // Each phase loads its length minus one; the phase ends when the counter hits zero.
  localparam logic [3:0] SETUP_LOAD   = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LOAD  = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LOAD    = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] RECOVER_LOAD = 4'(RECOVERY_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dir_q, dir_d;        // 1 = write transaction
  logic [1:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        cs_n_q, cs_n_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
  logic        oe_q, oe_d;
  logic        ack_q, ack_d;
  logic        busy_d;

  // Next-state sequencing and registered-output decode from the upcoming state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (chipselect && (read || write)) begin
          state_d = SETUP;
          cnt_d   = SETUP_LOAD;
          dir_d   = write;            // write wins when both are requested
          addr_d  = address;
          wdata_d = writedata;
        end
      end
      SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
          // Device data is sampled at the edge that ends the strobe.
          if (!dir_q) rdata_d = hpi_data_in;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = RECOVER;
          cnt_d   = RECOVER_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RECOVER: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    busy_d = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    cs_n_d = !busy_d;
    rd_n_d = !((state_d == STROBE) && !dir_d);
    wr_n_d = !((state_d == STROBE) && dir_d);
    oe_d   = busy_d && dir_d;
    ack_d  = (state_d == HOLD) && (cnt_d == 4'd0);
  end

  // State, latched request and all bus outputs; reset abandons any bus cycle at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      dir_q   <= 1'b0;
      addr_q  <= 2'd0;
      wdata_q <= 16'd0;
      rdata_q <= 16'd0;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cs_n_q  <= cs_n_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      oe_q    <= oe_d;
      ack_q   <= ack_d;
    end
  end

  assign readdata     = rdata_q;
  assign waitrequest  = ~ack_q;
  assign hpi_addr     = addr_q;
  assign hpi_cs_n     = cs_n_q;
  assign hpi_rd_n     = rd_n_q;
  assign hpi_wr_n     = wr_n_q;
  assign hpi_data_out = wdata_q;
  assign hpi_data_oe  = oe_q;

endmodule

// File: tb/tb_otg_hpi_bus_master.sv
// Bench for otg_hpi_bus_master: one instance with default timing and one with
// all phases at one cycle, both fed from the same Avalon/HPI stimulus.
module tb_otg_hpi_bus_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect, read, write;
  logic [15:0] writedata, hpi_data_in;

  logic [15:0] rdata    [2];
  logic [15:0] dout     [2];
  logic [1:0]  haddr    [2];
  logic [1:0]  wreq, cs_n, rd_n, wr_n, oe;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Phase lengths per instance: setup, strobe, hold, recovery.
  int ps[2] = '{2, 1};
  int pt[2] = '{4, 1};
  int ph[2] = '{2, 1};
  int pr[2] = '{3, 1};

  otg_hpi_bus_master u_def (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(rdata[0]),
    .waitrequest(wreq[0]), .hpi_addr(haddr[0]), .hpi_cs_n(cs_n[0]),
    .hpi_rd_n(rd_n[0]), .hpi_wr_n(wr_n[0]), .hpi_data_out(dout[0]),
    .hpi_data_oe(oe[0]), .hpi_data_in(hpi_data_in)
  );

  otg_hpi_bus_master #(
    .SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1), .RECOVERY_CYCLES(1)
  ) u_min (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(rdata[1]),
    .waitrequest(wreq[1]), .hpi_addr(haddr[1]), .hpi_cs_n(cs_n[1]),
    .hpi_rd_n(rd_n[1]), .hpi_wr_n(wr_n[1]), .hpi_data_out(dout[1]),
    .hpi_data_oe(oe[1]), .hpi_data_in(hpi_data_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Transaction-level model: a transaction is an accept cycle plus a direction;
  // every pin is derived from the offset of the current cycle from that accept.
  bit          m_act [2];
  int          m_st  [2];
  bit          m_dir [2];
  logic [1:0]  m_a   [2];
  logic [15:0] m_wd  [2];
  logic [15:0] m_rd  [2];

  task automatic model_step(input int i);
    int k;
    bit in_cs, strb, ack;
    string p;
    p = (i == 0) ? "def" : "min";
    if (!reset_n) begin
      m_act[i] = 1'b0; m_a[i] = 2'd0; m_wd[i] = 16'd0; m_rd[i] = 16'd0;
      chk({p, ".rst_cs_n"}, {15'd0, cs_n[i]}, 16'd1);
      chk({p, ".rst_rd_n"}, {15'd0, rd_n[i]}, 16'd1);
      chk({p, ".rst_wr_n"}, {15'd0, wr_n[i]}, 16'd1);
      chk({p, ".rst_oe"},   {15'd0, oe[i]},   16'd0);
      chk({p, ".rst_wreq"}, {15'd0, wreq[i]}, 16'd1);
      chk({p, ".rst_addr"}, {14'd0, haddr[i]}, 16'd0);
      chk({p, ".rst_dout"}, dout[i], 16'd0);
      chk({p, ".rst_rdata"}, rdata[i], 16'd0);
      return;
    end
    k     = m_act[i] ? (cyc - m_st[i]) : -1;
    in_cs = m_act[i] && k >= 1 && k <= ps[i] + pt[i] + ph[i];
    strb  = m_act[i] && k >= ps[i] + 1 && k <= ps[i] + pt[i];
    ack   = m_act[i] && k == ps[i] + pt[i] + ph[i];
    chk({p, ".cs_n"}, {15'd0, cs_n[i]}, {15'd0, !in_cs});
    chk({p, ".rd_n"}, {15'd0, rd_n[i]}, {15'd0, !(strb && !m_dir[i])});
    chk({p, ".wr_n"}, {15'd0, wr_n[i]}, {15'd0, !(strb && m_dir[i])});
    chk({p, ".oe"},   {15'd0, oe[i]},   {15'd0, in_cs && m_dir[i]});
    chk({p, ".waitrequest"}, {15'd0, wreq[i]}, {15'd0, !ack});
    chk({p, ".hpi_addr"}, {14'd0, haddr[i]}, {14'd0, m_a[i]});
    chk({p, ".readdata"}, rdata[i], m_rd[i]);
    if (in_cs && m_dir[i]) chk({p, ".data_out"}, dout[i], m_wd[i]);
    // Advance the model after this cycle's outputs have been judged.
    if (m_act[i] && !m_dir[i] && k == ps[i] + pt[i]) m_rd[i] = hpi_data_in;
    if (!m_act[i]) begin
      if (chipselect && (read || write)) begin
        m_act[i] = 1'b1; m_st[i] = cyc; m_dir[i] = write;
        m_a[i] = address; m_wd[i] = writedata;
      end
    end else if (k >= ps[i] + pt[i] + ph[i] + pr[i]) begin
      m_act[i] = 1'b0;
    end
  endtask

  // Compare both instances against the model on every cycle once the reset has taken hold.
  always @(negedge clk) begin
    if (cyc >= 2) begin
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  task automatic idle_req();
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; address = 2'd0; writedata = 16'd0; hpi_data_in = 16'd0;
    idle_req();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset.cs_n", {15'd0, cs_n[0]}, 16'd1);
    chk("reset.waitrequest", {15'd0, wreq[0]}, 16'd1);
    chk("reset.readdata", rdata[0], 16'h0000);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Single write of 0x1234 to address 2.
    chipselect = 1'b1; write = 1'b1; address = 2'd2; writedata = 16'h1234;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      case (k)
        0: chk("wr.cs_n_k0", {15'd0, cs_n[0]}, 16'd1);
        1: begin chk("wr.cs_n_k1", {15'd0, cs_n[0]}, 16'd0);
                 chk("min.wr_n_k1", {15'd0, wr_n[1]}, 16'd1); end
        2: begin chk("wr.wr_n_k2", {15'd0, wr_n[0]}, 16'd1);
                 chk("min.wr_n_k2", {15'd0, wr_n[1]}, 16'd0); end
        3: begin chk("wr.wr_n_k3", {15'd0, wr_n[0]}, 16'd0);
                 chk("min.waitrequest_k3", {15'd0, wreq[1]}, 16'd0); end
        4: begin chk("wr.data_out_k4", dout[0], 16'h1234);
                 chk("wr.hpi_addr_k4", {14'd0, haddr[0]}, 16'd2);
                 chk("min.cs_n_k4", {15'd0, cs_n[1]}, 16'd1); end
        6: chk("wr.wr_n_k6", {15'd0, wr_n[0]}, 16'd0);
        7: begin chk("wr.wr_n_k7", {15'd0, wr_n[0]}, 16'd1);
                 chk("wr.waitrequest_k7", {15'd0, wreq[0]}, 16'd1); end
        8: begin chk("wr.waitrequest_k8", {15'd0, wreq[0]}, 16'd0);
                 chk("wr.cs_n_k8", {15'd0, cs_n[0]}, 16'd0); end
        9: chk("wr.cs_n_k9", {15'd0, cs_n[0]}, 16'd1);
        default: ;
      endcase
      @(posedge clk); #1;
      if (k + 1 == 1) begin idle_req(); writedata = 16'hFFFF; address = 2'd1; end
    end

    // Read of address 0; device data drops to zero after the capture edge.
    chipselect = 1'b1; read = 1'b1; address = 2'd0; hpi_data_in = 16'hBEEF;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      case (k)
        4: begin chk("rd.rd_n_k4", {15'd0, rd_n[0]}, 16'd0);
                 chk("rd.oe_k4", {15'd0, oe[0]}, 16'd0); end
        8:  chk("rd.readdata_k8", rdata[0], 16'hBEEF);
        12: chk("rd.readdata_k12", rdata[0], 16'hBEEF);
        default: ;
      endcase
      @(posedge clk); #1;
      if (k + 1 == 1) idle_req();
      if (k + 1 == 7) hpi_data_in = 16'h0000;
    end

    // Back-to-back writes with the request held through cycle 12.
    chipselect = 1'b1; write = 1'b1; address = 2'd1; writedata = 16'h0101;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      case (k)
        5:  chk("b2b.min_cs_n_k5", {15'd0, cs_n[1]}, 16'd1);
        6:  chk("b2b.min_cs_n_k6", {15'd0, cs_n[1]}, 16'd0);
        8:  chk("b2b.waitrequest_k8", {15'd0, wreq[0]}, 16'd0);
        9:  chk("b2b.cs_n_k9", {15'd0, cs_n[0]}, 16'd1);
        12: chk("b2b.cs_n_k12", {15'd0, cs_n[0]}, 16'd1);
        13: chk("b2b.cs_n_k13", {15'd0, cs_n[0]}, 16'd0);
        20: chk("b2b.waitrequest_k20", {15'd0, wreq[0]}, 16'd0);
        default: ;
      endcase
      @(posedge clk); #1;
      if (k + 1 == 13) idle_req();
    end

    // read and write together: the write wins and readdata is untouched.
    chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 2'd3;
    writedata = 16'h00A5; hpi_data_in = 16'h5555;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      case (k)
        3: begin chk("both.wr_n_k3", {15'd0, wr_n[0]}, 16'd0);
                 chk("both.rd_n_k3", {15'd0, rd_n[0]}, 16'd1);
                 chk("both.data_out_k3", dout[0], 16'h00A5); end
        8: chk("both.readdata_k8", rdata[0], 16'hBEEF);
        default: ;
      endcase
      @(posedge clk); #1;
      if (k + 1 == 1) idle_req();
    end

    // Reset in the middle of a write, then a normal read.
    chipselect = 1'b1; write = 1'b1; address = 2'd2; writedata = 16'h7777;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      case (k)
        3: chk("rst.wr_n_k3", {15'd0, wr_n[0]}, 16'd0);
        4: begin chk("rst.cs_n_k4", {15'd0, cs_n[0]}, 16'd1);
                 chk("rst.wr_n_k4", {15'd0, wr_n[0]}, 16'd1);
                 chk("rst.oe_k4", {15'd0, oe[0]}, 16'd0);
                 chk("rst.waitrequest_k4", {15'd0, wreq[0]}, 16'd1); end
        15: chk("rst.waitrequest_k15", {15'd0, wreq[0]}, 16'd1);
        16: begin chk("rst.waitrequest_k16", {15'd0, wreq[0]}, 16'd0);
                  chk("rst.readdata_k16", rdata[0], 16'h0F0F); end
        default: ;
      endcase
      @(posedge clk); #1;
      if (k + 1 == 1) idle_req();
      if (k + 1 == 4) reset_n = 1'b0;
      if (k + 1 == 6) reset_n = 1'b1;
      if (k + 1 == 8) begin
        chipselect = 1'b1; read = 1'b1; address = 2'd3; hpi_data_in = 16'h0F0F;
      end
      if (k + 1 == 9) idle_req();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/otg_hpi_bus_master.md
Name: otg_hpi_bus_master

Overview:
- Avalon-MM slave that turns single 16-bit CPU accesses into timed HPI bus cycles toward the CY7C67200 EZ-OTG.
- Replaces software bit-banging of the write-only chip-select/strobe PIOs.
- Adds the inbound direction: it samples device read data and returns it on readdata.
- Sits between the Nios II data master and the top-level OTG_* pins; the tri-state buffer lives at the top level.

Parameters:
SETUP_CYCLES, 2, cycles of cs_n low with address valid before the strobe (1..15)
STROBE_CYCLES, 4, cycles the rd_n/wr_n strobe is held low (1..15)
HOLD_CYCLES, 2, cycles of cs_n low after the strobe rises; address and write data held (1..15)
RECOVERY_CYCLES, 3, cycles of cs_n high before the next transaction may start (1..15)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  HPI register select (0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS)
chipselect  in  1  Avalon slave select
read  in  1  Avalon read request
write  in  1  Avalon write request
writedata  in  16  write data
readdata  out  16  read data, valid in the ack cycle of a read
waitrequest  out  1  Avalon stall; low only in the ack cycle
hpi_addr  out  2  HPI address pins
hpi_cs_n  out  1  HPI chip select, active low
hpi_rd_n  out  1  HPI read strobe, active low
hpi_wr_n  out  1  HPI write strobe, active low
hpi_data_out  out  16  data driven toward the device
hpi_data_oe  out  1  tri-state enable for hpi_data_out
hpi_data_in  in  16  data from the device pins

Behaviour:
- Reset is asynchronous and active-low on reset_n; clock is clk.
- Reset values: hpi_cs_n=1, hpi_rd_n=1, hpi_wr_n=1, hpi_data_oe=0, hpi_addr=0, hpi_data_out=0, readdata=0, waitrequest=1. State=IDLE and all counters=0.
- All outputs are registered. waitrequest = ~ack, where ack is a registered one-cycle pulse.
- States: IDLE -> SETUP -> STROBE -> HOLD -> RECOVER -> IDLE.
- IDLE, accept condition: chipselect & (read | write), sampled in cycle T0.
  - Latch address, writedata and dir. dir=write if write=1; if read and write are both 1, write wins.
  - Enter SETUP in T0+1.
- SETUP (SETUP_CYCLES cycles):
  - hpi_cs_n=0 and hpi_addr=latched address.
  - For a write, hpi_data_oe=1 and hpi_data_out=latched data.
  - Strobes stay high.
- STROBE (STROBE_CYCLES cycles): hpi_rd_n=0 for a read, or hpi_wr_n=0 for a write.
  - For a read, hpi_data_in is captured into readdata on the clock edge ending the last STROBE cycle (no synchronizer).
  - hpi_data_in changes after that edge have no effect.
- HOLD (HOLD_CYCLES cycles): both strobes=1; cs_n, addr, data_out and oe unchanged.
  - ack=1 during the last HOLD cycle only, so waitrequest=0 for exactly one cycle.
  - Ack cycle = T0 + SETUP_CYCLES + STROBE_CYCLES + HOLD_CYCLES.
- RECOVER (RECOVERY_CYCLES cycles): hpi_cs_n=1, hpi_data_oe=0, hpi_addr keeps its last value.
  - Requests present are not accepted; waitrequest stays 1.
  - Return to IDLE; the earliest next accept is ack cycle + RECOVERY_CYCLES + 1.
- readdata holds its value until the next read capture. Writes never modify it.
- chipselect/read/write deasserting mid-transaction is ignored: the transaction completes and ack is still pulsed.
- An Avalon request held after ack is treated as a new request once IDLE is reached.
- Assertion of reset_n mid-transaction: all outputs return to their reset values immediately (asynchronously). The partial bus cycle is abandoned; no ack.
- A single 4-bit down-counter is reloaded with (param-1) on each state entry. A state advances when the counter reaches 0.

Test Plan:
- Defaults, write 0x1234 to address 2, accepted at cycle 0 -> hpi_cs_n=0 cycles 1–8; hpi_wr_n=0 cycles 3–6; hpi_data_oe=1 cycles 1–8 with hpi_data_out=0x1234; hpi_addr=2; waitrequest=0 only at cycle 8; hpi_rd_n stays 1.
- Read address 0, hpi_data_in=0xBEEF during strobe, switched to 0x0000 at cycle 7 -> hpi_rd_n=0 cycles 3–6; readdata=0xBEEF at ack cycle 8 and held afterwards; hpi_data_oe stays 0.
- Back-to-back writes with the request held continuously -> second transaction accepted at cycle 12; its hpi_cs_n falls at cycle 13; hpi_cs_n=1 during cycles 9–12.
- read=1 and write=1 together with writedata=0x00A5 -> write cycle performed (hpi_wr_n pulses, hpi_rd_n stays 1); readdata unchanged.
- reset_n asserted at cycle 4 of a write -> same cycle: hpi_cs_n=1, hpi_wr_n=1, hpi_data_oe=0, waitrequest=1. After release, a new read completes normally with ack 8 cycles after its accept.
- SETUP=1, STROBE=1, HOLD=1, RECOVERY=1 -> ack at cycle 3, next accept at cycle 5, single-cycle strobe at cycle 2.
